// File: rtl/warp_fetch_ctrl_pkg.sv
// Shared types and sizing for the per-warp instruction fetch front end.
package warp_fetch_ctrl_pkg;

    localparam int NUM_WARPS = 8;
    localparam int WID_W     = 3;
    localparam int PC_W      = 32;
    localparam int INSTR_W   = 32;
    localparam int PC_STEP   = 4;
    localparam int IB_DEPTH  = 2;
    localparam int CRED_W    = $clog2(IB_DEPTH + 1);

    typedef enum logic [1:0] {
        WS_IDLE      = 2'd0,
        WS_READY     = 2'd1,
        WS_INFLIGHT  = 2'd2,
        WS_MISS_WAIT = 2'd3
    } warp_state_e;

endpackage

// File: rtl/warp_fetch_slot.sv
// One warp's fetch state: FSM, PC and instruction-buffer credit counter.
module warp_fetch_slot
    import warp_fetch_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PC_W-1:0]   start_pc,
    input  logic              done,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              ib_release,
    input  logic              grant,
    input  logic              resp_vld,
    input  logic              resp_hit,
    input  logic              refill_done,
    output logic              request,
    output logic [PC_W-1:0]   pc,
    output logic [CRED_W-1:0] credits,
    output warp_state_e       state
);

    localparam logic [CRED_W-1:0] IB_FULL = CRED_W'(IB_DEPTH);

    warp_state_e       state_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [CRED_W-1:0] cred_nxt;
    logic              take;
    logic              ret;
    logic              rel;

    assign request = (state == WS_READY) && (credits != '0);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        take      = (state == WS_READY) && grant && (credits != '0);
        ret       = (state == WS_INFLIGHT) && resp_vld && !resp_hit;
        rel       = ib_release && (credits != IB_FULL);
        cred_nxt  = credits + CRED_W'(rel) + CRED_W'(ret) - CRED_W'(take);

        case (state)
            WS_IDLE: begin
                if (start) begin
                    state_nxt = WS_READY;
                    pc_nxt    = start_pc;
                    cred_nxt  = IB_FULL;
                end
            end
            WS_READY: begin
                if (take) state_nxt = WS_INFLIGHT;
            end
            WS_INFLIGHT: begin
                if (resp_vld) begin
                    if (resp_hit) begin
                        state_nxt = WS_READY;
                        pc_nxt    = pc + PC_W'(PC_STEP);
                    end else begin
                        state_nxt = WS_MISS_WAIT;
                    end
                end
            end
            WS_MISS_WAIT: begin
                if (refill_done) state_nxt = WS_READY;
            end
            default: state_nxt = WS_IDLE;
        endcase

        // Redirect flushes the IB downstream, so credits refill with it.
        if (redirect && (state != WS_IDLE)) begin
            state_nxt = WS_READY;
            pc_nxt    = redirect_pc;
            cred_nxt  = IB_FULL;
        end

        if (done) state_nxt = WS_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WS_IDLE;
            pc      <= '0;
            credits <= IB_FULL;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            credits <= cred_nxt;
        end
    end

endmodule

// File: rtl/warp_fetch_ctrl.sv
// Per-warp fetch front end: request generation, grant-to-port muxing and the
// one-cycle I-cache response pipe that writes the instruction buffers.
module warp_fetch_ctrl
    import warp_fetch_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Warp_Start_Valid,
    input  logic [WID_W-1:0]     Warp_Start_Id,
    input  logic [PC_W-1:0]      Warp_Start_PC,
    input  logic [NUM_WARPS-1:0] Warp_Done,
    input  logic                 Redirect_Valid,
    input  logic [WID_W-1:0]     Redirect_Warp,
    input  logic [PC_W-1:0]      Redirect_PC,
    input  logic [NUM_WARPS-1:0] IB_Release,
    output logic [NUM_WARPS-1:0] Icache_Fetch_Request,
    input  logic [NUM_WARPS-1:0] Grant1,
    input  logic [NUM_WARPS-1:0] Grant2,
    output logic                 Fetch1_Valid,
    output logic [PC_W-1:0]      Fetch1_PC,
    output logic                 Fetch2_Valid,
    output logic [PC_W-1:0]      Fetch2_PC,
    input  logic                 Icache_Hit1,
    input  logic                 Icache_Hit2,
    input  logic [INSTR_W-1:0]   Icache_Data1,
    input  logic [INSTR_W-1:0]   Icache_Data2,
    input  logic                 Icache_Refill_Done,
    output logic                 IB_Wr_Valid1,
    output logic [WID_W-1:0]     IB_Wr_Warp1,
    output logic [INSTR_W-1:0]   IB_Wr_Instr1,
    output logic [PC_W-1:0]      IB_Wr_PC1,
    output logic                 IB_Wr_Valid2,
    output logic [WID_W-1:0]     IB_Wr_Warp2,
    output logic [INSTR_W-1:0]   IB_Wr_Instr2,
    output logic [PC_W-1:0]      IB_Wr_PC2
);

    logic [PC_W-1:0]      pc      [NUM_WARPS];
    logic [CRED_W-1:0]    credits [NUM_WARPS];
    warp_state_e          state   [NUM_WARPS];
    logic [NUM_WARPS-1:0] resp_vld;
    logic [NUM_WARPS-1:0] resp_hit;
    logic [NUM_WARPS-1:0] redir_vec;
    logic [NUM_WARPS-1:0] kill_vec;

    logic [WID_W-1:0]     idx1_p0, idx2_p0;
    logic                 vld1_p0, vld2_p0;

    logic                 vld1_p1, vld2_p1;
    logic                 sq1_p1, sq2_p1;
    logic [WID_W-1:0]     warp1_p1, warp2_p1;
    logic [PC_W-1:0]      pc1_p1, pc2_p1;
    logic                 hit_ok1, hit_ok2;

    assign redir_vec = Redirect_Valid ? (NUM_WARPS'(1) << Redirect_Warp) : '0;
    assign kill_vec  = redir_vec | Warp_Done;

    genvar gw;
    generate
        for (gw = 0; gw < NUM_WARPS; gw++) begin : g_slot
            warp_fetch_slot u_slot (
                .clk         (clk),
                .rst_n       (rst_n),
                .start       (Warp_Start_Valid && (Warp_Start_Id == WID_W'(gw))),
                .start_pc    (Warp_Start_PC),
                .done        (Warp_Done[gw]),
                .redirect    (redir_vec[gw]),
                .redirect_pc (Redirect_PC),
                .ib_release  (IB_Release[gw]),
                .grant       (Grant1[gw] || Grant2[gw]),
                .resp_vld    (resp_vld[gw]),
                .resp_hit    (resp_hit[gw]),
                .refill_done (Icache_Refill_Done),
                .request     (Icache_Fetch_Request[gw]),
                .pc          (pc[gw]),
                .credits     (credits[gw]),
                .state       (state[gw])
            );

            assert property (@(posedge clk) disable iff (!rst_n)
                IB_Release[gw] |-> (credits[gw] != CRED_W'(IB_DEPTH)));
        end
    endgenerate

    // Stage p0: one-hot grants select the port address and warp index.
    always_comb begin
        Fetch1_PC = '0;
        Fetch2_PC = '0;
        idx1_p0   = '0;
        idx2_p0   = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            Fetch1_PC = Fetch1_PC | ({PC_W{Grant1[w]}} & pc[w]);
            Fetch2_PC = Fetch2_PC | ({PC_W{Grant2[w]}} & pc[w]);
            idx1_p0   = idx1_p0 | ({WID_W{Grant1[w]}} & WID_W'(w));
            idx2_p0   = idx2_p0 | ({WID_W{Grant2[w]}} & WID_W'(w));
        end
    end

    assign Fetch1_Valid = |Grant1;
    assign Fetch2_Valid = |Grant2;
    assign vld1_p0      = |(Grant1 & Icache_Fetch_Request);
    assign vld2_p0      = |(Grant2 & Icache_Fetch_Request);

    // Stage p1: response pipe; grants colliding with redirect/done are pre-squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_p1 <= 1'b0;
            vld2_p1 <= 1'b0;
            sq1_p1  <= 1'b0;
            sq2_p1  <= 1'b0;
        end else begin
            vld1_p1 <= vld1_p0;
            vld2_p1 <= vld2_p0;
            sq1_p1  <= kill_vec[idx1_p0];
            sq2_p1  <= kill_vec[idx2_p0];
        end
    end

    always_ff @(posedge clk) begin
        warp1_p1 <= idx1_p0;
        warp2_p1 <= idx2_p0;
        pc1_p1   <= Fetch1_PC;
        pc2_p1   <= Fetch2_PC;
    end

    always_comb begin
        resp_vld = '0;
        resp_hit = '0;
        if (vld1_p1 && !sq1_p1) begin
            resp_vld[warp1_p1] = 1'b1;
            resp_hit[warp1_p1] = Icache_Hit1;
        end
        if (vld2_p1 && !sq2_p1) begin
            resp_vld[warp2_p1] = 1'b1;
            resp_hit[warp2_p1] = Icache_Hit2;
        end
    end

    assign hit_ok1 = vld1_p1 && Icache_Hit1 && !sq1_p1 && !kill_vec[warp1_p1];
    assign hit_ok2 = vld2_p1 && Icache_Hit2 && !sq2_p1 && !kill_vec[warp2_p1];

    assign IB_Wr_Valid1 = hit_ok1;
    assign IB_Wr_Warp1  = hit_ok1 ? warp1_p1 : '0;
    assign IB_Wr_Instr1 = hit_ok1 ? Icache_Data1 : '0;
    assign IB_Wr_PC1    = hit_ok1 ? pc1_p1 : '0;
    assign IB_Wr_Valid2 = hit_ok2;
    assign IB_Wr_Warp2  = hit_ok2 ? warp2_p1 : '0;
    assign IB_Wr_Instr2 = hit_ok2 ? Icache_Data2 : '0;
    assign IB_Wr_PC2    = hit_ok2 ? pc2_p1 : '0;

    assert property (@(posedge clk) disable iff (!rst_n) (Grant1 & Grant2) == '0);
    assert property (@(posedge clk) disable iff (!rst_n)
        Warp_Start_Valid |-> (state[Warp_Start_Id] == WS_IDLE));

endmodule

// File: tb/tb_warp_fetch_ctrl.sv
// Directed bench for warp_fetch_ctrl; the bench plays the arbiter and I-cache.
module tb_warp_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Warp_Start_Valid;
    logic [2:0]  Warp_Start_Id;
    logic [31:0] Warp_Start_PC;
    logic [7:0]  Warp_Done;
    logic        Redirect_Valid;
    logic [2:0]  Redirect_Warp;
    logic [31:0] Redirect_PC;
    logic [7:0]  IB_Release;
    logic [7:0]  Icache_Fetch_Request;
    logic [7:0]  Grant1, Grant2;
    logic        Fetch1_Valid, Fetch2_Valid;
    logic [31:0] Fetch1_PC, Fetch2_PC;
    logic        Icache_Hit1, Icache_Hit2;
    logic [31:0] Icache_Data1, Icache_Data2;
    logic        Icache_Refill_Done;
    logic        IB_Wr_Valid1, IB_Wr_Valid2;
    logic [2:0]  IB_Wr_Warp1, IB_Wr_Warp2;
    logic [31:0] IB_Wr_Instr1, IB_Wr_Instr2, IB_Wr_PC1, IB_Wr_PC2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    warp_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .Warp_Start_Valid(Warp_Start_Valid), .Warp_Start_Id(Warp_Start_Id),
        .Warp_Start_PC(Warp_Start_PC), .Warp_Done(Warp_Done),
        .Redirect_Valid(Redirect_Valid), .Redirect_Warp(Redirect_Warp),
        .Redirect_PC(Redirect_PC), .IB_Release(IB_Release),
        .Icache_Fetch_Request(Icache_Fetch_Request),
        .Grant1(Grant1), .Grant2(Grant2),
        .Fetch1_Valid(Fetch1_Valid), .Fetch1_PC(Fetch1_PC),
        .Fetch2_Valid(Fetch2_Valid), .Fetch2_PC(Fetch2_PC),
        .Icache_Hit1(Icache_Hit1), .Icache_Hit2(Icache_Hit2),
        .Icache_Data1(Icache_Data1), .Icache_Data2(Icache_Data2),
        .Icache_Refill_Done(Icache_Refill_Done),
        .IB_Wr_Valid1(IB_Wr_Valid1), .IB_Wr_Warp1(IB_Wr_Warp1),
        .IB_Wr_Instr1(IB_Wr_Instr1), .IB_Wr_PC1(IB_Wr_PC1),
        .IB_Wr_Valid2(IB_Wr_Valid2), .IB_Wr_Warp2(IB_Wr_Warp2),
        .IB_Wr_Instr2(IB_Wr_Instr2), .IB_Wr_PC2(IB_Wr_PC2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge and drop all pulse inputs.
    task automatic cyc();
        @(posedge clk);
        #1;
        Warp_Start_Valid   = 1'b0;
        Warp_Done          = '0;
        Redirect_Valid     = 1'b0;
        IB_Release         = '0;
        Grant1             = '0;
        Grant2             = '0;
        Icache_Hit1        = 1'b0;
        Icache_Hit2        = 1'b0;
        Icache_Refill_Done = 1'b0;
    endtask

    task automatic start(input logic [2:0] id, input logic [31:0] spc);
        Warp_Start_Valid = 1'b1;
        Warp_Start_Id    = id;
        Warp_Start_PC    = spc;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".req"},  64'(Icache_Fetch_Request), 64'h0);
        chk({tag, ".f1v"},  64'(Fetch1_Valid), 64'h0);
        chk({tag, ".f2v"},  64'(Fetch2_Valid), 64'h0);
        chk({tag, ".ib1v"}, 64'(IB_Wr_Valid1), 64'h0);
        chk({tag, ".ib2v"}, 64'(IB_Wr_Valid2), 64'h0);
        chk({tag, ".ib1pc"}, 64'(IB_Wr_PC1), 64'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        Warp_Start_Id = '0; Warp_Start_PC = '0;
        Redirect_Warp = '0; Redirect_PC = '0;
        Icache_Data1 = 32'hDEAD_0001; Icache_Data2 = 32'hDEAD_0002;
        cyc();
        cyc();
        #2 chk_quiet("reset");
        rst_n = 1'b1;

        // 1: w0 @0x100 and w5 @0x200, hits, no releases
        cyc(); start(3'd0, 32'h100);
        cyc(); start(3'd5, 32'h200);
        #1 chk("t1.req0", 64'(Icache_Fetch_Request), 64'h01);
        Grant1 = 8'h01;
        #1 chk("t1.f1v", 64'(Fetch1_Valid), 64'h1);
        chk("t1.f1pc0", 64'(Fetch1_PC), 64'h100);
        cyc(); Icache_Hit1 = 1'b1; Icache_Data1 = 32'hAAAA_0100;
        #1 chk("t1.ib1v", 64'(IB_Wr_Valid1), 64'h1);
        chk("t1.ib1w", 64'(IB_Wr_Warp1), 64'h0);
        chk("t1.ib1pc", 64'(IB_Wr_PC1), 64'h100);
        chk("t1.ib1i", 64'(IB_Wr_Instr1), 64'hAAAA_0100);
        chk("t1.req1", 64'(Icache_Fetch_Request), 64'h20);
        Grant2 = 8'h20;
        #1 chk("t1.f2pc0", 64'(Fetch2_PC), 64'h200);
        cyc(); Icache_Hit2 = 1'b1; Icache_Data2 = 32'hBBBB_0200;
        #1 chk("t1.ib2w", 64'(IB_Wr_Warp2), 64'h5);
        chk("t1.ib2pc", 64'(IB_Wr_PC2), 64'h200);
        chk("t1.req2", 64'(Icache_Fetch_Request), 64'h01);
        Grant1 = 8'h01;
        #1 chk("t1.f1pc1", 64'(Fetch1_PC), 64'h104);
        cyc(); Icache_Hit1 = 1'b1;
        #1 chk("t1.ib1pc1", 64'(IB_Wr_PC1), 64'h104);
        chk("t1.req3", 64'(Icache_Fetch_Request), 64'h20);
        Grant2 = 8'h20;
        #1 chk("t1.f2pc1", 64'(Fetch2_PC), 64'h204);
        cyc(); Icache_Hit2 = 1'b1;
        #1 chk("t1.ib2pc1", 64'(IB_Wr_PC2), 64'h204);
        chk("t1.req4", 64'(Icache_Fetch_Request), 64'h00);
        cyc();
        #1 chk("t1.req5", 64'(Icache_Fetch_Request), 64'h00);
        Warp_Done = 8'h21;

        // 2: w3 misses, refill, re-request at same PC with credit returned
        cyc(); start(3'd3, 32'h300);
        cyc(); Grant1 = 8'h08;
        cyc(); Icache_Hit1 = 1'b0;
        #1 chk("t2.ib1v", 64'(IB_Wr_Valid1), 64'h0);
        cyc();
        #1 chk("t2.reqmiss", 64'(Icache_Fetch_Request), 64'h00);
        Icache_Refill_Done = 1'b1;
        cyc();
        #1 chk("t2.reqre", 64'(Icache_Fetch_Request), 64'h08);
        Grant1 = 8'h08;
        #1 chk("t2.f1pc", 64'(Fetch1_PC), 64'h300);
        cyc(); Icache_Hit1 = 1'b1;
        #1 chk("t2.ib1pc", 64'(IB_Wr_PC1), 64'h300);
        cyc();
        #1 chk("t2.reqcred", 64'(Icache_Fetch_Request), 64'h08);
        Warp_Done = 8'h08;

        // 3: redirect w2 in its response cycle with a hit
        cyc(); start(3'd2, 32'h240);
        cyc(); Grant1 = 8'h04;
        cyc(); Icache_Hit1 = 1'b1;
        Redirect_Valid = 1'b1; Redirect_Warp = 3'd2; Redirect_PC = 32'h400;
        #1 chk("t3.ib1v", 64'(IB_Wr_Valid1), 64'h0);
        cyc();
        #1 chk("t3.req", 64'(Icache_Fetch_Request), 64'h04);
        Grant1 = 8'h04;
        #1 chk("t3.f1pc", 64'(Fetch1_PC), 64'h400);
        cyc(); Icache_Hit1 = 1'b1;
        #1 chk("t3.ib1pc", 64'(IB_Wr_PC1), 64'h400);
        cyc();
        #1 chk("t3.reqcred", 64'(Icache_Fetch_Request), 64'h04);
        Warp_Done = 8'h04;

        // 4: dual grant, w1 on port 1 and w6 on port 2
        cyc(); start(3'd1, 32'h1000);
        cyc(); start(3'd6, 32'h6000);
        cyc();
        #1 chk("t4.req", 64'(Icache_Fetch_Request), 64'h42);
        Grant1 = 8'h02; Grant2 = 8'h40;
        #1 chk("t4.f1pc", 64'(Fetch1_PC), 64'h1000);
        chk("t4.f2pc", 64'(Fetch2_PC), 64'h6000);
        cyc(); Icache_Hit1 = 1'b1; Icache_Hit2 = 1'b1;
        #1 chk("t4.ib1v", 64'(IB_Wr_Valid1), 64'h1);
        chk("t4.ib2v", 64'(IB_Wr_Valid2), 64'h1);
        chk("t4.ib1w", 64'(IB_Wr_Warp1), 64'h1);
        chk("t4.ib2w", 64'(IB_Wr_Warp2), 64'h6);
        chk("t4.ib1pc", 64'(IB_Wr_PC1), 64'h1000);
        chk("t4.ib2pc", 64'(IB_Wr_PC2), 64'h6000);
        cyc(); Warp_Done = 8'h42;

        // 5: credits=1, grant and release in the same cycle net to zero
        cyc(); start(3'd4, 32'h500);
        cyc(); Grant1 = 8'h10;
        cyc(); Icache_Hit1 = 1'b1;
        cyc();
        #1 chk("t5.req1", 64'(Icache_Fetch_Request), 64'h10);
        Grant1 = 8'h10; IB_Release = 8'h10;
        #1 chk("t5.f1pc", 64'(Fetch1_PC), 64'h504);
        cyc(); Icache_Hit1 = 1'b1;
        #1 chk("t5.ib1pc", 64'(IB_Wr_PC1), 64'h504);
        cyc();
        #1 chk("t5.reqnet", 64'(Icache_Fetch_Request), 64'h10);
        Warp_Done = 8'h10;

        // 6: done on an INFLIGHT warp, then asynchronous reset mid-stream
        cyc(); start(3'd7, 32'h700);
        cyc(); Grant1 = 8'h80;
        cyc(); Icache_Hit1 = 1'b1; Warp_Done = 8'h80;
        #1 chk("t6.ib1v", 64'(IB_Wr_Valid1), 64'h0);
        cyc();
        #1 chk("t6.reqidle", 64'(Icache_Fetch_Request), 64'h00);
        start(3'd0, 32'h10);
        cyc(); Grant1 = 8'h01;
        cyc(); Icache_Hit1 = 1'b1;
        #1 chk("t6.pre", 64'(IB_Wr_Valid1), 64'h1);
        rst_n = 1'b0;
        #1 chk_quiet("t6.rst");
        cyc();
        #1 chk_quiet("t6.rst2");
        rst_n = 1'b1;
        cyc(); Icache_Hit1 = 1'b1;
        #1 chk_quiet("t6.post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
